// File: rtl/uks_return_mux.sv
// Return-path collector for the UKS board: picks one of N_MOD module return lines per
// channel (OSN/REZ) by qualified control address, with break-before-make and activity flags.
module uks_return_mux #(
  parameter int         N_MOD       = 16,
  parameter logic [3:0] BASE_ID     = 4'hA,
  parameter int         QUAL_CYC    = 16,
  parameter int         GUARD_CYC   = 8,
  parameter logic       IDLE_LVL    = 1'b1,
  parameter int         ACT_TIMEOUT = 50000
) (
  input  logic             clk_50_MHz,
  input  logic             NRESET,
  input  logic [7:0]       addr,
  input  logic [N_MOD-1:0] din_osn,
  input  logic [N_MOD-1:0] din_rez,
  output logic             dataout_osn,
  output logic             dataout_rez,
  output logic             sel_valid,
  output logic [3:0]       sel_ch,
  output logic             addr_err,
  output logic             act_osn,
  output logic             act_rez
);

  // state | meaning
  // IDLE  | nothing connected, outputs at IDLE_LVL
  // GUARD | break-before-make hold, outputs at IDLE_LVL, counting down
  // PASS  | selected module routed to dataout_*
  typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_PASS} state_t;

  localparam logic [7:0]  QUAL_MAX = 8'(QUAL_CYC);
  localparam logic [7:0]  QUAL_LD  = 8'(QUAL_CYC - 1);
  localparam logic [7:0]  GUARD_LD = 8'(GUARD_CYC - 1);
  localparam logic [15:0] ACT_MAX  = 16'(ACT_TIMEOUT);
  localparam logic [4:0]  N_MOD_W  = 5'(N_MOD);

  logic [7:0]       addr_s1_q, addr_s2_q, a_prev_q;
  logic [N_MOD-1:0] osn_s1_q, osn_s2_q, rez_s1_q, rez_s2_q;
  logic [7:0]       q_cnt_q, q_cnt_d;
  logic             addr_err_q, addr_err_d;
  state_t           state_q, state_d;
  logic [3:0]       tgt_q, tgt_d;
  logic [3:0]       sel_ch_q, sel_ch_d;
  logic [7:0]       g_cnt_q, g_cnt_d;
  logic             sel_valid_q, sel_valid_d;
  logic [1:0]       dout_q, dout_d;
  logic [1:0]       act_q, act_d;
  logic [1:0][15:0] act_cnt_q, act_cnt_d;

  logic       a_same, a_q_ld, a_ok, pass_d;
  logic [3:0] a_idx;

  always_comb begin
    a_same  = (addr_s2_q == a_prev_q);
    a_idx   = addr_s2_q[3:0];
    a_ok    = (addr_s2_q[7:4] == BASE_ID) && ({1'b0, a_idx} < N_MOD_W);
    a_q_ld  = a_same && (q_cnt_q == QUAL_LD);
    q_cnt_d = '0;
    if (a_same) q_cnt_d = (q_cnt_q == QUAL_MAX) ? q_cnt_q : q_cnt_q + 8'd1;
    addr_err_d = a_q_ld ? !a_ok : addr_err_q;
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    g_cnt_d  = g_cnt_q;
    sel_ch_d = sel_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (a_q_ld && a_ok) begin
          state_d = ST_GUARD;
          tgt_d   = a_idx;
          g_cnt_d = GUARD_LD;
        end
      end
      ST_GUARD: begin
        if (a_q_ld) begin
          if (a_ok) begin
            tgt_d   = a_idx;
            g_cnt_d = GUARD_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (g_cnt_q == 8'd0) begin
          state_d  = ST_PASS;
          sel_ch_d = tgt_q;
        end else begin
          g_cnt_d = g_cnt_q - 8'd1;
        end
      end
      ST_PASS: begin
        if (a_q_ld) begin
          if (!a_ok) begin
            state_d = ST_IDLE;
          end else if (a_idx != sel_ch_q) begin
            state_d = ST_GUARD;
            tgt_d   = a_idx;
            g_cnt_d = GUARD_LD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output mux keys off the next state so the guard never leaks a stale sample.
  always_comb begin
    pass_d      = (state_d == ST_PASS);
    sel_valid_d = pass_d;
    dout_d      = {IDLE_LVL, IDLE_LVL};
    if (pass_d) dout_d = {rez_s2_q[sel_ch_d], osn_s2_q[sel_ch_d]};
  end

  always_comb begin
    act_cnt_d = act_cnt_q;
    act_d     = act_q;
    for (int i = 0; i < 2; i++) begin
      if (!pass_d) begin
        act_cnt_d[i] = ACT_MAX;
        act_d[i]     = 1'b0;
      end else if (dout_d[i] != dout_q[i]) begin
        act_cnt_d[i] = '0;
        act_d[i]     = 1'b1;
      end else begin
        if (act_cnt_q[i] != ACT_MAX) act_cnt_d[i] = act_cnt_q[i] + 16'd1;
        if (act_cnt_d[i] == ACT_MAX) act_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50_MHz or negedge NRESET) begin
    if (!NRESET) begin
      addr_s1_q   <= {8{IDLE_LVL}};
      addr_s2_q   <= {8{IDLE_LVL}};
      a_prev_q    <= {8{IDLE_LVL}};
      osn_s1_q    <= {N_MOD{IDLE_LVL}};
      osn_s2_q    <= {N_MOD{IDLE_LVL}};
      rez_s1_q    <= {N_MOD{IDLE_LVL}};
      rez_s2_q    <= {N_MOD{IDLE_LVL}};
      q_cnt_q     <= '0;
      addr_err_q  <= 1'b0;
      state_q     <= ST_IDLE;
      tgt_q       <= '0;
      sel_ch_q    <= '0;
      g_cnt_q     <= '0;
      sel_valid_q <= 1'b0;
      dout_q      <= {IDLE_LVL, IDLE_LVL};
      act_q       <= '0;
      act_cnt_q   <= '0;
    end else begin
      addr_s1_q   <= addr;
      addr_s2_q   <= addr_s1_q;
      a_prev_q    <= addr_s2_q;
      osn_s1_q    <= din_osn;
      osn_s2_q    <= osn_s1_q;
      rez_s1_q    <= din_rez;
      rez_s2_q    <= rez_s1_q;
      q_cnt_q     <= q_cnt_d;
      addr_err_q  <= addr_err_d;
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      sel_ch_q    <= sel_ch_d;
      g_cnt_q     <= g_cnt_d;
      sel_valid_q <= sel_valid_d;
      dout_q      <= dout_d;
      act_q       <= act_d;
      act_cnt_q   <= act_cnt_d;
    end
  end

  assign dataout_osn = dout_q[0];
  assign dataout_rez = dout_q[1];
  assign sel_valid   = sel_valid_q;
  assign sel_ch      = sel_ch_q;
  assign addr_err    = addr_err_q;
  assign act_osn     = act_q[0];
  assign act_rez     = act_q[1];

endmodule
